// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// FRAME_PARSER_TIMEOUT_EN in the top enables the inter-word timeout.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        ERR_LEN  = 2'd0,
        ERR_CSUM = 2'd1,
        ERR_OVF  = 2'd2,
        ERR_TMO  = 2'd3
    } err_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic len_valid(
        input logic [7:0]  len,
        input int unsigned max_len
    );
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port,
// one combinational read port, contents not reset.
module uart_frame_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses {SYNC,LEN} + payload + XOR-checksum frames from a UART word stream.
// Define FRAME_PARSER_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         W              = 16,
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC           = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         frame_ok,
    output logic         frame_err,
    output logic [1:0]   err_code
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t       state_q, state_d;
    logic [7:0]   len_q, len_d;
    logic [7:0]   wr_q, wr_d;
    logic [7:0]   rd_q, rd_d;
    logic [W-1:0] csum_q, csum_d;
    logic         ok_q, ok_d;
    logic         err_q, err_d;
    err_t         code_q, code_d;
    logic         we;
    logic [W-1:0] rdata;
    logic [7:0]   hdr_len;
    logic         hdr_sync;
    logic         drain;
    logic         at_last;

    assign hdr_len  = s_data[7:0];
    assign hdr_sync = (s_data[15:8] == SYNC);
    assign drain    = (state_q == ST_DRAIN);
    assign at_last  = (rd_q == len_q - 8'd1);

`ifdef FRAME_PARSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    uart_frame_buf #(
        .W     (W),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (wr_q[AW-1:0]),
        .wdata (s_data),
        .raddr (rd_q[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        csum_d  = csum_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_LEN;
        we      = 1'b0;
`ifdef FRAME_PARSER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && hdr_sync) begin
                    if (!len_valid(hdr_len, MAX_LEN)) begin
                        err_d  = 1'b1;
                        code_d = ERR_LEN;
                    end else begin
                        len_d   = hdr_len;
                        csum_d  = s_data;
                        wr_d    = 8'd0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (s_valid) begin
                    we     = 1'b1;
                    csum_d = csum_q ^ s_data;
                    wr_d   = wr_q + 8'd1;
                    if (wr_q == len_q - 8'd1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (s_valid) begin
                    if (s_data == csum_q) begin
                        ok_d    = 1'b1;
                        rd_d    = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                // Words arriving mid-drain are lost; flag but keep draining.
                if (s_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVF;
                end
                if (m_ready) begin
                    rd_d = rd_q + 8'd1;
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef FRAME_PARSER_TIMEOUT_EN
        if ((state_q == ST_PAYLOAD || state_q == ST_CHECK) && !s_valid) begin
            if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                code_d  = ERR_TMO;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            len_q   <= 8'd0;
            wr_q    <= 8'd0;
            rd_q    <= 8'd0;
            csum_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_LEN;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            csum_q  <= csum_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

`ifdef FRAME_PARSER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign m_valid   = drain;
    assign m_data    = drain ? rdata : '0;
    assign m_last    = drain && at_last;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

endmodule
